clock_divider_multi: RTL and testbench

//  NUM_CH independent counter-based clock dividers on one system clock.

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clock_divider_channel.sv | 81 ++++++++
 rtl/clock_divider_multi.sv | 68 ++++++
 tb/tb_clock_divider_multi.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clkdiv_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Toggle-mode divide value for a target output frequency. Integer division
    // truncates, so the result can land one count away from a hand-picked value.
    function automatic longint unsigned div_for_hz(input longint unsigned clk_hz,
                                                   input longint unsigned hz);
        return clk_hz / (2 * hz) - 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: terminal-count counter, active and shadow divide/mode,
// and registered clk_out/tick outputs.
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_acc,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow_div;
    logic             mode;
    logic             shadow_mode;
    logic             tc;
    logic             apply;

    assign tc    = (cnt == div);
    // A stopped channel takes the new setting at once; a running one waits for
    // the end of its current period so no runt pulse is produced.
    assign apply = pend & (~en | tc);

    // Shadow capture on accept and transfer to the active setting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_div  <= '0;
            shadow_mode <= MODE_TOGGLE;
            div         <= DEFAULT_DIV;
            mode        <= MODE_TOGGLE;
            pend        <= 1'b0;
        end else begin
            if (cfg_acc) begin
                shadow_div  <= cfg_div;
                shadow_mode <= cfg_mode;
            end
            if (apply) begin
                div  <= shadow_div;
                mode <= shadow_mode;
            end
            pend <= cfg_acc | (pend & ~apply);
        end
    end

    // Counter and output generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (tc) begin
            cnt  <= '0;
            tick <= 1'b1;
            // On a mode switch, toggle restarts low and pulse follows tick (high).
            if (apply && (shadow_mode != mode))
                clk_out <= shadow_mode;
            else if (mode == MODE_PULSE)
                clk_out <= 1'b1;
            else
                clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
            clk_out <= (mode == MODE_TOGGLE) ? clk_out : 1'b0;
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing one config port.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    // 12 Hz toggle at 100 MHz; div_for_hz() truncates to one count lower.
    parameter int unsigned DEFAULT_DIV = 32'd4166666,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [1:0]        rst_pipe;
    logic              rst_int;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] acc;

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rst_pipe <= 2'b11;
        else
            rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign rst_int = rst_pipe[1];

    // Channel decode and ready mux; out-of-range channels are always ready and
    // their requests fall on the floor.
    always_comb begin
        cfg_ready = 1'b1;
        acc       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
                acc[i]    = cfg_valid & ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
        ) u_ch (
            .clk      (clk),
            .rst      (rst_int),
            .en       (en[g]),
            .cfg_acc  (acc[g]),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .pend     (pend[g]),
            .clk_out  (clk_out[g]),
            .tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: expected tick intervals / output patterns are
// queued when stimulus is applied and popped as the DUT produces them.
module tb_clock_divider_multi;

    localparam int DEF = 3;

    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic [3:0] clk_out;
    logic [3:0] tick;

    logic [2:0] en2;
    logic       cfg_valid2;
    logic       cfg_ready2;
    logic [1:0] cfg_ch2;
    logic [7:0] cfg_div2;
    logic       cfg_mode2;
    logic [2:0] clk_out2;
    logic [2:0] tick2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    clock_divider_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .clk_out(clk_out), .tick(tick)
    );

    clock_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(DEF)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_ch(cfg_ch2), .cfg_div(cfg_div2), .cfg_mode(cfg_mode2),
        .clk_out(clk_out2), .tick(tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cyc_step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for the next tick on a channel; reports its cycle and how many
    // times clk_out changed while waiting (including the change at the tick).
    task automatic tick_wait(input bit sel2, input int ch, input int max,
                             output int t, output int chg, output bit ok);
        logic prev, cur, tk;
        prev = sel2 ? clk_out2[ch] : clk_out[ch];
        chg = 0;
        ok  = 1'b0;
        t   = 0;
        for (int k = 0; k < max; k++) begin
            @(posedge clk);
            #1;
            cur = sel2 ? clk_out2[ch] : clk_out[ch];
            if (cur !== prev) chg++;
            prev = cur;
            tk = sel2 ? tick2[ch] : tick[ch];
            if (tk === 1'b1) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int t, chg, e, last, t_rel;
        bit ok;
        cyc_step(2);
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: clk_out=%h tick=%h expected 0/0", clk_out, tick);
        end
        cfg_ch = 2'd0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        rst   = 1'b0;
        en    = 4'hF;
        en2   = 3'b111;
        t_rel = cyc;
        exp_q.push_back(t_rel + 2 + DEF + 1);
        for (int i = 0; i < 3; i++) exp_q.push_back(DEF + 1);
        tick_wait(0, 0, 30, t, chg, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || t !== e) begin
            failures++;
            $display("FAIL first_tick: got cycle %0d (ok=%0d) expected %0d", t, ok, e);
        end
        checks++;
        if (clk_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL first_toggle: clk_out0=%b expected 1", clk_out[0]);
        end
        last = t;
        cyc_step(1);
        checks++;
        if (tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL tick_width: tick0=%b expected 0", tick[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick_wait(0, 0, 30, t, chg, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || (t - last) !== e || chg !== 1) begin
                failures++;
                $display("FAIL default_period: interval %0d chg %0d expected %0d chg 1", t - last, chg, e);
            end
            last = t;
        end
    endtask

    task automatic test_reprogram_toggle();
        int t, chg, e, last, t0;
        bit ok;
        tick_wait(0, 1, 30, t0, chg, ok);
        cyc_step(1);
        cfg_ch    = 2'd1;
        cfg_div   = 8'd4;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reprog_ready: got %b expected 1", cfg_ready);
        end
        exp_q.push_back(DEF + 1);
        exp_q.push_back(5);
        exp_q.push_back(5);
        cyc_step(1);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reprog_pend: cfg_ready=%b expected 0", cfg_ready);
        end
        last = t0;
        for (int i = 0; i < 3; i++) begin
            tick_wait(0, 1, 30, t, chg, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || (t - last) !== e || chg !== 1) begin
                failures++;
                $display("FAIL reprog_period: interval %0d chg %0d expected %0d chg 1", t - last, chg, e);
            end
            if (i == 0) begin
                checks++;
                if (cfg_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL reprog_applied: cfg_ready=%b expected 1", cfg_ready);
                end
            end
            last = t;
        end
    endtask

    task automatic test_pulse_mode();
        int t0, chg, t_ready;
        bit ok;
        logic e;
        tick_wait(0, 2, 30, t0, chg, ok);
        cfg_ch    = 2'd2;
        cfg_div   = 8'd2;
        cfg_mode  = 1'b1;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL pulse_ready: got %b expected 1", cfg_ready);
        end
        cyc_step(1);
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pulse_hold: cfg_ready=%b expected 0", cfg_ready);
        end
        exp_q.push_back(t0 + DEF + 1);
        t_ready = -1;
        for (int k = 0; k < 10; k++) begin
            if (cfg_ready === 1'b1) begin
                t_ready = cyc;
                break;
            end
            cyc_step(1);
        end
        checks++;
        if (t_ready !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL pulse_ready_release: ready at %0d expected %0d", t_ready, t0 + DEF + 1);
        end
        for (int k = 0; k < 9; k++) exp_q.push_back((k % 3) == 0);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cyc_step(1);
            if (k == 1) cfg_valid = 1'b0;
            e = logic'(exp_q.pop_front());
            checks++;
            if (clk_out[2] !== e || tick[2] !== e) begin
                failures++;
                $display("FAIL pulse_pattern[%0d]: clk_out2=%b tick2=%b expected %b", k, clk_out[2], tick[2], e);
            end
            if (k == 1 || k == 3) begin
                checks++;
                if (cfg_ready !== (k == 3)) begin
                    failures++;
                    $display("FAIL pulse_second_pend[%0d]: cfg_ready=%b expected %b", k, cfg_ready, k == 3);
                end
            end
        end
    endtask

    task automatic test_disable();
        int t0, t, chg, e, last, t_en;
        bit ok;
        tick_wait(0, 3, 30, t0, chg, ok);
        cyc_step(1);
        en[3] = 1'b0;
        cyc_step(1);
        checks++;
        if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
            failures++;
            $display("FAIL disable_out: clk_out3=%b tick3=%b expected 0/0", clk_out[3], tick[3]);
        end
        for (int k = 0; k < 3; k++) begin
            cyc_step(1);
            checks++;
            if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
                failures++;
                $display("FAIL disable_hold: clk_out3=%b tick3=%b expected 0/0", clk_out[3], tick[3]);
            end
        end
        cfg_ch    = 2'd3;
        cfg_div   = 8'd1;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL disable_cfg_ready: got %b expected 1", cfg_ready);
        end
        cyc_step(1);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL disable_cfg_pend: cfg_ready=%b expected 0", cfg_ready);
        end
        cyc_step(1);
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL disable_cfg_apply: cfg_ready=%b expected 1", cfg_ready);
        end
        en[3] = 1'b1;
        t_en  = cyc;
        exp_q.push_back(t_en + 2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        tick_wait(0, 3, 30, t, chg, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || t !== e || clk_out[3] !== 1'b1) begin
            failures++;
            $display("FAIL reenable_first: tick at %0d clk_out3=%b expected %0d/1", t, clk_out[3], e);
        end
        last = t;
        for (int i = 0; i < 2; i++) begin
            tick_wait(0, 3, 30, t, chg, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || (t - last) !== e || chg !== 1) begin
                failures++;
                $display("FAIL reenable_period: interval %0d chg %0d expected %0d chg 1", t - last, chg, e);
            end
            last = t;
        end
    endtask

    task automatic test_cfg_at_tc();
        int t0, t, chg, e, last;
        bit ok;
        tick_wait(0, 0, 30, t0, chg, ok);
        cyc_step(DEF);
        cfg_ch    = 2'd0;
        cfg_div   = 8'd6;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL tc_cfg_ready: got %b expected 1", cfg_ready);
        end
        exp_q.push_back(DEF + 1);
        exp_q.push_back(DEF + 1);
        exp_q.push_back(7);
        exp_q.push_back(7);
        cyc_step(1);
        cfg_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (tick[0] !== 1'b1 || (cyc - t0) !== e || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL tc_same_cycle: tick0=%b interval %0d ready=%b expected 1/%0d/0",
                     tick[0], cyc - t0, cfg_ready, e);
        end
        last = cyc;
        for (int i = 0; i < 3; i++) begin
            tick_wait(0, 0, 30, t, chg, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || (t - last) !== e || chg !== 1) begin
                failures++;
                $display("FAIL tc_period[%0d]: interval %0d chg %0d expected %0d chg 1", i, t - last, chg, e);
            end
            if (i == 0) begin
                checks++;
                if (cfg_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL tc_apply: cfg_ready=%b expected 1", cfg_ready);
                end
            end
            last = t;
        end
    endtask

    task automatic test_out_of_range();
        int t0, chg, e;
        bit ok;
        tick_wait(1, 0, 30, t0, chg, ok);
        cfg_ch2    = 2'd3;
        cfg_div2   = 8'd9;
        cfg_mode2  = 1'b1;
        cfg_valid2 = 1'b1;
        #1;
        checks++;
        if (cfg_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL oor_ready: got %b expected 1", cfg_ready2);
        end
        cyc_step(1);
        cfg_valid2 = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            cfg_ch2 = 2'(ch);
            #1;
            checks++;
            if (cfg_ready2 !== 1'b1) begin
                failures++;
                $display("FAIL oor_no_pend[%0d]: cfg_ready=%b expected 1", ch, cfg_ready2);
            end
        end
        for (int k = 2; k < 14; k++) exp_q.push_back(((k % (DEF + 1)) == 0) ? 7 : 0);
        for (int k = 2; k < 14; k++) begin
            cyc_step(1);
            e = exp_q.pop_front();
            checks++;
            if (tick2 !== 3'(e) || (clk_out2 !== 3'b000 && clk_out2 !== 3'b111)) begin
                failures++;
                $display("FAIL oor_channels[%0d]: tick=%b clk_out=%b expected tick %b, outputs equal",
                         k, tick2, clk_out2, 3'(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, t, chg, e, t_rel;
        bit ok;
        tick_wait(0, 1, 30, t0, chg, ok);
        cfg_ch    = 2'd1;
        cfg_div   = 8'd9;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b1;
        cyc_step(1);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pend: cfg_ready=%b expected 0", cfg_ready);
        end
        for (int k = 0; k < 4; k++) begin
            if (clk_out !== 4'h0) break;
            cyc_step(1);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || clk_out2 !== 3'b000 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async: clk_out=%h tick=%h clk_out2=%b ready=%b expected 0/0/0/1",
                     clk_out, tick, clk_out2, cfg_ready);
        end
        cyc_step(2);
        rst   = 1'b0;
        t_rel = cyc;
        exp_q.push_back(t_rel + 2 + DEF + 1);
        exp_q.push_back(DEF + 1);
        tick_wait(0, 1, 30, t, chg, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || t !== e || clk_out !== 4'hF || tick !== 4'hF) begin
            failures++;
            $display("FAIL rstmid_restart: tick at %0d clk_out=%h tick=%h expected %0d/F/F", t, clk_out, tick, e);
        end
        t0 = t;
        tick_wait(0, 1, 30, t, chg, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || (t - t0) !== e || clk_out !== 4'h0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_default: interval %0d clk_out=%h ready=%b expected %0d/0/1",
                     t - t0, clk_out, cfg_ready, e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 4'h0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_div    = 8'd0;
        cfg_mode   = 1'b0;
        en2        = 3'b000;
        cfg_valid2 = 1'b0;
        cfg_ch2    = 2'd0;
        cfg_div2   = 8'd0;
        cfg_mode2  = 1'b0;
        test_reset();
        test_reprogram_toggle();
        test_pulse_mode();
        test_disable();
        test_cfg_at_tc();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
